timeout_retry_ctrl: RTL and testbench

- Sequences a request/acknowledge transaction using a prescaled tick counter as the timeout datapath.
- Asserts req to a downstream agent and waits for ack. On timeout it backs off and retries, up to a bounded number of retries.
- Reports completion (done) or exhaustion (fail) as single-cycle pulses.
- Sits between a host-side start/abort interface and any slow peripheral handshake.

---
 rtl/timeout_pkg.sv | 15 +
 rtl/timeout_retry_ctrl_if.sv | 34 +++
 rtl/tick_prescaler.sv | 29 ++
 rtl/timeout_retry_ctrl.sv | 138 +++++++++++++
 tb/tb_timeout_retry_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/timeout_pkg.sv
// rtl/timeout_pkg.sv - shared state encoding and counter widths for timeout_retry_ctrl
package timeout_pkg;

    localparam int TICK_W  = 4;
    localparam int RETRY_W = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        BACKOFF = 3'd2,
        DONE    = 3'd3,
        FAIL    = 3'd4
    } state_t;

endpackage

// File: rtl/timeout_retry_ctrl_if.sv
// rtl/timeout_retry_ctrl_if.sv - host/downstream handshake bundle; fail_sticky under TIMEOUT_RETRY_STICKY_FAIL_EN
interface timeout_retry_ctrl_if;
    import timeout_pkg::*;

    logic               start;
    logic               ack;
    logic               abort;
    logic               req;
    logic               busy;
    logic               done;
    logic               fail;
    logic [TICK_W-1:0]  tick_cnt;
    logic [RETRY_W-1:0] retry_cnt;
`ifdef TIMEOUT_RETRY_STICKY_FAIL_EN
    logic               fail_sticky;
`endif

    modport master (
        output start, ack, abort,
`ifdef TIMEOUT_RETRY_STICKY_FAIL_EN
        input  fail_sticky,
`endif
        input  req, busy, done, fail, tick_cnt, retry_cnt
    );

    modport slave (
        input  start, ack, abort,
`ifdef TIMEOUT_RETRY_STICKY_FAIL_EN
        output fail_sticky,
`endif
        output req, busy, done, fail, tick_cnt, retry_cnt
    );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running 0..PRESCALE-1 counter producing a tick on its last count
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/timeout_retry_ctrl.sv
// rtl/timeout_retry_ctrl.sv - req/ack sequencer with tick timeout, backoff and bounded retries; optional TIMEOUT_RETRY_STICKY_FAIL_EN
module timeout_retry_ctrl
    import timeout_pkg::*;
#(
    parameter int PRESCALE       = 4,
    parameter int TIMEOUT_TICKS  = 5,
    parameter int MAX_RETRIES    = 3,
    parameter int BACKOFF_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    timeout_retry_ctrl_if.slave  bus
);

    localparam int BO_W = $clog2(BACKOFF_CYCLES + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TIMEOUT_TICKS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);
    localparam logic [BO_W-1:0]    BO_LAST    = BO_W'(BACKOFF_CYCLES - 1);

    state_t             state;
    state_t             nxt;
    logic [TICK_W-1:0]  tick_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic [BO_W-1:0]    bo_cnt;
    logic               tick;
    logic               timeout;
    logic               req_q;
    logic               busy_q;
    logic               done_q;
    logic               fail_q;

    // Prescaler only runs in WAIT, so every attempt starts from a fresh count.
    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != WAIT),
        .en   (state == WAIT),
        .tick (tick)
    );

    assign timeout = tick && (tick_cnt == TICK_LAST);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (bus.start && !bus.abort) nxt = WAIT;
            WAIT: begin
                if (bus.abort)        nxt = IDLE;
                else if (bus.ack)     nxt = DONE;
                else if (timeout)     nxt = (retry_cnt < RETRY_MAX) ? BACKOFF : FAIL;
            end
            BACKOFF: begin
                if (bus.abort)             nxt = IDLE;
                else if (bo_cnt == BO_LAST) nxt = WAIT;
            end
            DONE:    nxt = IDLE;
            FAIL:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            retry_cnt <= '0;
            bo_cnt    <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state  <= nxt;
            req_q  <= (nxt == WAIT);
            busy_q <= (nxt != IDLE);
            done_q <= (nxt == DONE);
            fail_q <= (nxt == FAIL);
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    bo_cnt   <= '0;
                    if (nxt == WAIT) retry_cnt <= '0;
                end
                WAIT: begin
                    if (bus.abort) begin
                        tick_cnt  <= '0;
                        retry_cnt <= '0;
                    end else if (bus.ack) begin
                        tick_cnt <= tick_cnt;
                    end else if (timeout) begin
                        // tick_cnt is held at its last value through BACKOFF/FAIL.
                        bo_cnt <= '0;
                        if (nxt == BACKOFF) retry_cnt <= retry_cnt + RETRY_W'(1);
                    end else if (tick) begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                BACKOFF: begin
                    if (bus.abort) begin
                        tick_cnt  <= '0;
                        retry_cnt <= '0;
                        bo_cnt    <= '0;
                    end else if (nxt == WAIT) begin
                        tick_cnt <= '0;
                        bo_cnt   <= '0;
                    end else begin
                        bo_cnt <= bo_cnt + BO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TIMEOUT_RETRY_STICKY_FAIL_EN
    logic sticky_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sticky_q <= 1'b0;
        end else if (state == FAIL) begin
            sticky_q <= 1'b1;
        end else if (state == IDLE && bus.start && !bus.abort) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus.fail_sticky = sticky_q;
`endif

    assign bus.req       = req_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.tick_cnt  = tick_cnt;
    assign bus.retry_cnt = retry_cnt;

endmodule

// File: tb/tb_timeout_retry_ctrl.sv
// tb/tb_timeout_retry_ctrl.sv - scoreboard bench for timeout_retry_ctrl
module tb_timeout_retry_ctrl;

    typedef struct {
        int   cyc;
        logic req, busy, done, fail, sticky;
        int   tick;
        int   retry;
    } snap_t;

    typedef struct {
        int   cyc;
        logic is_fail;
        int   retry;
        int   req_cycles;
    } pulse_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   t0  = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   req_run = 0;

    snap_t  snap_q[$];
    pulse_t pulse_q[$];

    timeout_retry_ctrl_if bus();

    timeout_retry_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(input int rel);
        while (cyc < t0 + rel) step();
    endtask

    task automatic go();
        step();
        bus.start = 1'b1;
        t0 = cyc;
        step();
        bus.start = 1'b0;
    endtask

    task automatic snap(input int rel, input logic r, input logic b, input logic d,
                        input logic f, input int tk, input int rt, input logic s);
        snap_t e;
        e.cyc = t0 + rel; e.req = r; e.busy = b; e.done = d; e.fail = f;
        e.tick = tk; e.retry = rt; e.sticky = s;
        snap_q.push_back(e);
    endtask

    task automatic exp_pulse(input int rel, input logic is_fail, input int rt, input int rc);
        pulse_t p;
        p.cyc = t0 + rel; p.is_fail = is_fail; p.retry = rt; p.req_cycles = rc;
        pulse_q.push_back(p);
    endtask

    // Monitor: snapshot checks keyed on cycle, pulse checks popped on done/fail.
    always @(negedge clk) begin
        logic sticky_now;
        logic ok;
`ifdef TIMEOUT_RETRY_STICKY_FAIL_EN
        sticky_now = bus.fail_sticky;
`else
        sticky_now = 1'b0;
`endif
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            snap_t e;
            e = snap_q.pop_front();
            ok = (e.cyc == cyc) && bus.req === e.req && bus.busy === e.busy &&
                 bus.done === e.done && bus.fail === e.fail &&
                 (e.tick < 0 || int'(bus.tick_cnt) == e.tick) &&
                 (e.retry < 0 || int'(bus.retry_cnt) == e.retry);
`ifdef TIMEOUT_RETRY_STICKY_FAIL_EN
            ok = ok && (sticky_now === e.sticky);
`endif
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL snap@%0d (now %0d): got req=%b busy=%b done=%b fail=%b tick=%0d retry=%0d sticky=%b want req=%b busy=%b done=%b fail=%b tick=%0d retry=%0d sticky=%b",
                         e.cyc, cyc, bus.req, bus.busy, bus.done, bus.fail, bus.tick_cnt,
                         bus.retry_cnt, sticky_now, e.req, e.busy, e.done, e.fail, e.tick,
                         e.retry, e.sticky);
            end
        end
        if (bus.done === 1'b1 || bus.fail === 1'b1) begin
            n_cmp++;
            if (pulse_q.size() == 0) begin
                n_bad++;
                $display("FAIL pulse@%0d: got done=%b fail=%b want no pulse", cyc, bus.done, bus.fail);
            end else begin
                pulse_t p;
                p = pulse_q.pop_front();
                if (p.cyc != cyc || bus.fail !== p.is_fail || bus.done !== !p.is_fail ||
                    int'(bus.retry_cnt) != p.retry || req_run != p.req_cycles) begin
                    n_bad++;
                    $display("FAIL pulse@%0d: got cyc=%0d fail=%b retry=%0d req_cycles=%0d want cyc=%0d fail=%b retry=%0d req_cycles=%0d",
                             p.cyc, cyc, bus.fail, bus.retry_cnt, req_run, p.cyc, p.is_fail,
                             p.retry, p.req_cycles);
                end
            end
        end
        if (bus.busy !== 1'b1) req_run = 0;
        else if (bus.req === 1'b1) req_run = req_run + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b1;
        bus.ack   = 1'b0;
        bus.abort = 1'b0;
        rst       = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        bus.start = 1'b0;
        t0 = cyc;
        snap(0, 0, 0, 0, 0, 0, 0, 0);
        snap(1, 0, 0, 0, 0, 0, 0, 0);
        wait_rel(3);

        // ack at 6, stray start at 3 while busy
        go();
        snap(1, 1, 1, 0, 0, 0, 0, 0);
        snap(6, 1, 1, 0, 0, 1, 0, 0);
        snap(7, 0, 1, 1, 0, 1, 0, 0);
        snap(8, 0, 0, 0, 0, -1, 0, 0);
        exp_pulse(7, 1'b0, 0, 6);
        wait_rel(3); bus.start = 1'b1; step(); bus.start = 1'b0;
        wait_rel(6); bus.ack = 1'b1; step(); bus.ack = 1'b0;
        wait_rel(10);

        // start together with abort in IDLE is dropped
        step();
        bus.start = 1'b1; bus.abort = 1'b1; t0 = cyc;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        snap(1, 0, 0, 0, 0, 0, 0, 0);
        snap(2, 0, 0, 0, 0, 0, 0, 0);
        wait_rel(4);

        // no ack: all attempts time out
        go();
        snap(1,  1, 1, 0, 0, 0, 0, 0);
        snap(20, 1, 1, 0, 0, 4, 0, 0);
        snap(21, 0, 1, 0, 0, 4, 1, 0);
        snap(22, 0, 1, 0, 0, 4, 1, 0);
        snap(23, 1, 1, 0, 0, 0, 1, 0);
        snap(43, 0, 1, 0, 0, 4, 2, 0);
        snap(65, 0, 1, 0, 0, 4, 3, 0);
        snap(67, 1, 1, 0, 0, 0, 3, 0);
        snap(86, 1, 1, 0, 0, 4, 3, 0);
        snap(87, 0, 1, 0, 1, 4, 3, 0);
        snap(88, 0, 0, 0, 0, -1, 3, 1);
        exp_pulse(87, 1'b1, 3, 80);
        wait_rel(90);

        // abort in IDLE leaves sticky and retry_cnt alone
        step();
        bus.abort = 1'b1; t0 = cyc;
        step();
        bus.abort = 1'b0;
        snap(1, 0, 0, 0, 0, 0, 3, 1);
        wait_rel(3);

        // ack exactly on the timeout cycle wins
        go();
        snap(1,  1, 1, 0, 0, 0, 0, 0);
        snap(20, 1, 1, 0, 0, 4, 0, 0);
        snap(21, 0, 1, 1, 0, 4, 0, 0);
        snap(22, 0, 0, 0, 0, -1, 0, 0);
        exp_pulse(21, 1'b0, 0, 20);
        wait_rel(20); bus.ack = 1'b1; step(); bus.ack = 1'b0;
        wait_rel(24);

        // abort during BACKOFF, then restart at 30
        go();
        snap(21, 0, 1, 0, 0, 4, 1, 0);
        snap(22, 0, 1, 0, 0, 4, 1, 0);
        snap(23, 0, 0, 0, 0, 0, 0, 0);
        snap(29, 0, 0, 0, 0, 0, 0, 0);
        wait_rel(22); bus.abort = 1'b1; step(); bus.abort = 1'b0;
        wait_rel(29);
        go();
        snap(1, 1, 1, 0, 0, 0, 0, 0);
        snap(4, 0, 1, 1, 0, 0, 0, 0);
        exp_pulse(4, 1'b0, 0, 3);
        wait_rel(3); bus.ack = 1'b1; step(); bus.ack = 1'b0;
        wait_rel(8);

        // abort in DONE does not suppress the pulse
        go();
        snap(3, 0, 1, 1, 0, 0, 0, 0);
        snap(4, 0, 0, 0, 0, -1, 0, 0);
        exp_pulse(3, 1'b0, 0, 2);
        wait_rel(2); bus.ack = 1'b1; step(); bus.ack = 1'b0;
        bus.abort = 1'b1; step(); bus.abort = 1'b0;
        wait_rel(8);

        repeat (4) step();
        n_cmp++;
        if (snap_q.size() != 0 || pulse_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d snapshots and %0d pulses pending, want 0 and 0",
                     snap_q.size(), pulse_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
